// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Holds the PC, addresses the async
//               instruction ROM and registers the fetched word into the IR.
//               Handles start/halt sequencing, downstream stalls and taken
//               branches (one-cycle squash). Opcode 4'b1111 is HALT.
//               Optional macro FETCH_ICOUNT_EN adds a saturating 16-bit
//               retired-instruction counter on output Icount.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stall,
    input  logic               Branch_taken,
    input  logic [PC_W-1:0]    Branch_target,
    input  logic [INSTR_W-1:0] Rom_data,
    output logic [PC_W-1:0]    Rom_addr,
    output logic [INSTR_W-1:0] Instr,
    output logic [3:0]         Opcode,
    output logic               Valid,
    output logic [PC_W-1:0]    Instr_pc,
`ifdef FETCH_ICOUNT_EN
    output logic [15:0]        Icount,
`endif
    output logic               Done
);

    localparam logic [1:0]      c_IDLE    = 2'd0;
    localparam logic [1:0]      c_RUN     = 2'd1;
    localparam logic [1:0]      c_HALTED  = 2'd2;
    localparam logic [3:0]      c_HALT_OP = 4'hF;
    localparam logic [PC_W-1:0] c_PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state,   w_stateNxt;
    logic [PC_W-1:0]    r_pc,      w_pcNxt;
    logic [INSTR_W-1:0] r_instr,   w_instrNxt;
    logic [PC_W-1:0]    r_instrPc, w_instrPcNxt;
    logic               r_valid,   w_validNxt;
    logic               r_done,    w_doneNxt;
    logic [3:0]         w_romOp;
    logic               w_startAcc;

    assign w_romOp    = Rom_data[INSTR_W-1 -: 4];
    // Start only has an effect outside RUN
    assign w_startAcc = Start && (r_state != c_RUN);

    // Next-state and datapath update: stall > branch > halt > normal fetch
    always_comb begin
        w_stateNxt   = r_state;
        w_pcNxt      = r_pc;
        w_instrNxt   = r_instr;
        w_instrPcNxt = r_instrPc;
        w_validNxt   = r_valid;
        w_doneNxt    = r_done;
        case (r_state)
            c_IDLE, c_HALTED: begin
                if (Start) begin
                    w_stateNxt = c_RUN;
                    w_pcNxt    = '0;
                    w_validNxt = 1'b0;
                    w_doneNxt  = 1'b0;
                end
            end
            c_RUN: begin
                if (!Stall) begin
                    if (Branch_taken && r_valid) begin
                        // Redirect; the word fetched this cycle is squashed
                        w_pcNxt    = Branch_target;
                        w_validNxt = 1'b0;
                    end else if (w_romOp == c_HALT_OP) begin
                        // HALT is never issued; PC stays on the HALT address
                        w_stateNxt = c_HALTED;
                        w_validNxt = 1'b0;
                        w_doneNxt  = 1'b1;
                    end else begin
                        w_instrNxt   = Rom_data;
                        w_instrPcNxt = r_pc;
                        w_validNxt   = 1'b1;
                        w_pcNxt      = r_pc + c_PC_ONE;
                    end
                end
            end
            default: begin
                w_stateNxt = c_IDLE;
                w_validNxt = 1'b0;
            end
        endcase
    end

    // State and pipeline registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= c_IDLE;
            r_pc      <= '0;
            r_instr   <= '0;
            r_instrPc <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_stateNxt;
            r_pc      <= w_pcNxt;
            r_instr   <= w_instrNxt;
            r_instrPc <= w_instrPcNxt;
            r_valid   <= w_validNxt;
            r_done    <= w_doneNxt;
        end
    end

`ifdef FETCH_ICOUNT_EN
    logic [15:0] r_icount;

    // Count instructions leaving the IR, saturating at all-ones
    always_ff @(posedge CLK) begin
        if (Reset || w_startAcc) begin
            r_icount <= '0;
        end else if (r_valid && !Stall && (r_icount != 16'hFFFF)) begin
            r_icount <= r_icount + 16'd1;
        end
    end

    assign Icount = r_icount;
`else
    logic w_unusedStartAcc;
    assign w_unusedStartAcc = w_startAcc;
`endif

    assign Rom_addr = r_pc;
    assign Instr    = r_instr;
    assign Opcode   = r_instr[INSTR_W-1 -: 4];
    assign Valid    = r_valid;
    assign Instr_pc = r_instrPc;
    assign Done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomized scoreboard bench for fetch_unit. The reference
//               model predicts the program trace (sequence of fetched
//               addresses, taken branches and HALT) and the cycle by which
//               each step must appear; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int DEPTH   = 1 << PC_W;
    localparam int N_CYC   = 4000;

    logic               clk = 1'b0;
    logic               reset, start, stall, branchTaken;
    logic [PC_W-1:0]    branchTarget, romAddr, instrPc;
    logic [INSTR_W-1:0] romData, instr;
    logic [3:0]         opcode;
    logic               valid, done;
`ifdef FETCH_ICOUNT_EN
    logic [15:0]        icount;
`endif

    logic [INSTR_W-1:0] rom [DEPTH];
    assign romData = rom[romAddr];

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .CLK           (clk),
        .Reset         (reset),
        .Start         (start),
        .Stall         (stall),
        .Branch_taken  (branchTaken),
        .Branch_target (branchTarget),
        .Rom_data      (romData),
        .Rom_addr      (romAddr),
        .Instr         (instr),
        .Opcode        (opcode),
        .Valid         (valid),
        .Instr_pc      (instrPc),
`ifdef FETCH_ICOUNT_EN
        .Icount        (icount),
`endif
        .Done          (done)
    );

    typedef struct {
        bit                 isHalt;
        logic [PC_W-1:0]    addr;
        logic [INSTR_W-1:0] word;
        int                 pushEdge;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic bit isHaltWord(logic [INSTR_W-1:0] w);
        return w[INSTR_W-1 -: 4] == 4'hF;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic pushExp(logic [PC_W-1:0] a, int e);
        exp_t x;
        x.addr     = a;
        x.word     = rom[a];
        x.isHalt   = isHaltWord(rom[a]);
        x.pushEdge = e;
        expQ.push_back(x);
    endtask

    // Stimulus driver: inputs change on the falling edge
    initial begin
        logic [INSTR_W-1:0] w;
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        branchTaken = 1'b0; branchTarget = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w = INSTR_W'($urandom);
            if (isHaltWord(w) && ($urandom_range(0, 3) != 0)) w[INSTR_W-1 -: 4] = 4'd0;
            if (i >= DEPTH - 4 && isHaltWord(w)) w[INSTR_W-1 -: 4] = 4'd9;
            rom[i] = w;
        end
        rom[0] = {4'd0, 5'h05};   // ADD
        rom[1] = {4'd2, 5'h03};   // XOR
        rom[2] = {4'd8, 5'h11};   // ACC
        rom[3] = {4'hF, 5'h00};   // HALT
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        for (int c = 0; c < N_CYC; c++) begin
            reset = (c == 2000);
            start = ($urandom_range(0, 9) == 0);
            // A branch raised under stall is held until the stall drops
            if (!(branchTaken && stall)) begin
                branchTaken = ($urandom_range(0, 4) == 0);
                case ($urandom_range(0, 3))
                    0:       branchTarget = PC_W'($urandom_range(0, DEPTH - 1));
                    1:       branchTarget = PC_W'(DEPTH - 4);
                    2:       branchTarget = PC_W'(32);
                    default: branchTarget = PC_W'(DEPTH - 1);
                endcase
            end
            stall = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        reset = 1'b0; start = 1'b0; stall = 1'b0; branchTaken = 1'b0;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Reference model plus monitor: samples inputs at the edge, outputs 1 ns later
    initial begin
        bit              mRunning, mLive, mDone;
        logic [PC_W-1:0] mLast, succ;
        int              mIcount, edgeN;
        logic            sReset, sStart, sStall, sBr;
        logic [PC_W-1:0] sTgt;
        bit              heldLive, startAcc;
        exp_t            e;
        mRunning = 0; mLive = 0; mDone = 0; mLast = '0; mIcount = 0; edgeN = 0;
        forever begin
            @(posedge clk);
            edgeN++;
            sReset = reset; sStart = start; sStall = stall;
            sBr = branchTaken; sTgt = branchTarget;
            #1;
            if (sReset) begin
                expQ.delete();
                mRunning = 0; mLive = 0; mDone = 0; mIcount = 0;
                check("rst_valid", valid, 0);
                check("rst_done", done, 0);
                check("rst_instr", instr, 0);
                check("rst_instr_pc", instrPc, 0);
                check("rst_pc", romAddr, 0);
`ifdef FETCH_ICOUNT_EN
                check("rst_icount", icount, 0);
`endif
                continue;
            end
            heldLive = mLive && sStall;
            startAcc = sStart && !mRunning;
            if (startAcc) begin
                pushExp('0, edgeN);
                mRunning = 1; mDone = 0; mIcount = 0;
                check("start_valid", valid, 0);
            end else if (mLive && !sStall) begin
                // Live instruction retires; program continues at target or next address
                if (mIcount < 65535) mIcount++;
                succ = mLast + 1'b1;
                pushExp(sBr ? sTgt : succ, edgeN);
                mLive = 0;
            end
            if (heldLive) begin
                check("hold_valid", valid, 1);
                check("hold_instr_pc", instrPc, mLast);
                check("hold_instr", instr, rom[mLast]);
            end else if (valid) begin
                if (expQ.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_issue: actual pc=%0h required no issue", instrPc);
                end else begin
                    e = expQ.pop_front();
                    check("issue_kind_halt", e.isHalt, 0);
                    check("issue_instr_pc", instrPc, e.addr);
                    check("issue_instr", instr, e.word);
                    check("issue_opcode", opcode, e.word[INSTR_W-1 -: 4]);
                    mLive = 1;
                    mLast = e.addr;
                end
            end
            if (done && !mDone) begin
                if (expQ.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: actual done=1 required 0");
                end else begin
                    e = expQ.pop_front();
                    check("halt_kind", e.isHalt, 1);
                    check("halt_pc", romAddr, e.addr);
                    check("halt_valid", valid, 0);
                    mRunning = 0;
                    mDone = 1;
                end
            end
            check("done_level", done, mDone);
            if (expQ.size() > 0 && expQ[0].pushEdge < edgeN && !sStall) begin
                checks++; failures++;
                $display("FAIL latency: actual no output at edge %0d required pc=%0h", edgeN, expQ[0].addr);
                void'(expQ.pop_front());
            end
`ifdef FETCH_ICOUNT_EN
            check("icount", icount, mIcount);
`endif
        end
    end

endmodule
`default_nettype wire
